// File: rtl/spi_txn_ctrl.sv
// Framed SPI transaction sequencer: wraps a byte-level SPI master with chip-select
// setup/hold/idle timing and streams a host byte sequence through it.
module spi_txn_ctrl #(
  parameter int unsigned MAX_BYTES     = 16,
  parameter int unsigned CS_SETUP_CLKS = 2,
  parameter int unsigned CS_HOLD_CLKS  = 2,
  parameter int unsigned CS_IDLE_CLKS  = 4,
  localparam int unsigned LEN_W        = $clog2(MAX_BYTES + 1)
) (
  input  logic             clk_i,
  input  logic             reset_l_i,
  // Transaction request
  input  logic             txn_start_i,
  input  logic [LEN_W-1:0] txn_len_i,
  output logic             txn_busy_o,
  output logic             txn_done_o,
  // Host byte stream
  input  logic [7:0]       host_tx_byte_i,
  input  logic             host_tx_valid_i,
  output logic             host_tx_ready_o,
  output logic [7:0]       host_rx_byte_o,
  output logic             host_rx_valid_o,
  // Byte-level SPI master
  output logic [7:0]       m_tx_byte_o,
  output logic             m_tx_valid_o,
  input  logic             m_tx_ready_i,
  input  logic [7:0]       m_rx_byte_i,
  input  logic             m_rx_valid_i,
  output logic             spi_cs_n_o
);

  // Timing parameters below 1 would collapse a phase to zero cycles; floor them.
  localparam int unsigned SetupClks = (CS_SETUP_CLKS < 1) ? 1 : CS_SETUP_CLKS;
  localparam int unsigned HoldClks  = (CS_HOLD_CLKS < 1) ? 1 : CS_HOLD_CLKS;
  localparam int unsigned IdleClks  = (CS_IDLE_CLKS < 1) ? 1 : CS_IDLE_CLKS;

  localparam int unsigned MaxClks01 = (SetupClks > HoldClks) ? SetupClks : HoldClks;
  localparam int unsigned MaxClks   = (MaxClks01 > IdleClks) ? MaxClks01 : IdleClks;
  localparam int unsigned CntW      = (MaxClks > 1) ? $clog2(MaxClks) : 1;

  localparam logic [CntW-1:0]  SetupLast = CntW'(SetupClks - 1);
  localparam logic [CntW-1:0]  HoldLast  = CntW'(HoldClks - 1);
  localparam logic [CntW-1:0]  IdleLast  = CntW'(IdleClks - 1);
  localparam logic [LEN_W-1:0] LenMax    = LEN_W'(MAX_BYTES);
  localparam logic [LEN_W-1:0] LenOne    = LEN_W'(1);

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StLoad,
    StSend,
    StWaitRx,
    StHold,
    StGap
  } state_e;

  state_e           state_q;
  logic [CntW-1:0]  cnt_q;
  logic [LEN_W-1:0] remaining_q;
  logic [LEN_W-1:0] len_clamped;

  always_comb begin
    len_clamped = txn_len_i;
    if (txn_len_i > LenMax) begin
      len_clamped = LenMax;
    end
  end

  // The only combinational output: the host may present a byte only while loading.
  assign host_tx_ready_o = (state_q == StLoad);

  always_ff @(posedge clk_i or negedge reset_l_i) begin
    if (!reset_l_i) begin
      state_q         <= StIdle;
      cnt_q           <= '0;
      remaining_q     <= '0;
      spi_cs_n_o      <= 1'b1;
      txn_busy_o      <= 1'b0;
      txn_done_o      <= 1'b0;
      m_tx_byte_o     <= 8'h00;
      m_tx_valid_o    <= 1'b0;
      host_rx_byte_o  <= 8'h00;
      host_rx_valid_o <= 1'b0;
    end else begin
      txn_done_o      <= 1'b0;
      m_tx_valid_o    <= 1'b0;
      host_rx_valid_o <= 1'b0;

      unique case (state_q)
        StIdle: begin
          if (txn_start_i && (txn_len_i != '0)) begin
            remaining_q <= len_clamped;
            cnt_q       <= '0;
            spi_cs_n_o  <= 1'b0;
            txn_busy_o  <= 1'b1;
            state_q     <= StSetup;
          end
        end

        StSetup: begin
          if (cnt_q == SetupLast) begin
            cnt_q   <= '0;
            state_q <= StLoad;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end

        // Host underrun is legal: wait here with CS still asserted.
        StLoad: begin
          if (host_tx_valid_i) begin
            m_tx_byte_o <= host_tx_byte_i;
            state_q     <= StSend;
          end
        end

        StSend: begin
          if (m_tx_ready_i) begin
            m_tx_valid_o <= 1'b1;
            state_q      <= StWaitRx;
          end
        end

        StWaitRx: begin
          if (m_rx_valid_i) begin
            host_rx_byte_o  <= m_rx_byte_i;
            host_rx_valid_o <= 1'b1;
            remaining_q     <= remaining_q - LenOne;
            if (remaining_q == LenOne) begin
              cnt_q   <= '0;
              state_q <= StHold;
            end else begin
              state_q <= StLoad;
            end
          end
        end

        StHold: begin
          if (cnt_q == HoldLast) begin
            cnt_q      <= '0;
            spi_cs_n_o <= 1'b1;
            txn_done_o <= 1'b1;
            state_q    <= StGap;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end

        // Busy stays high through the gap so a new request cannot shorten CS idle time.
        StGap: begin
          if (cnt_q == IdleLast) begin
            cnt_q      <= '0;
            txn_busy_o <= 1'b0;
            state_q    <= StIdle;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_txn_ctrl.sv
// Directed bench for spi_txn_ctrl with a loopback byte-level SPI master model and an
// rx-byte scoreboard.
module tb_spi_txn_ctrl;

  localparam int unsigned MaxBytes  = 16;
  localparam int unsigned SetupClks = 2;
  localparam int unsigned HoldClks  = 2;
  localparam int unsigned IdleClks  = 4;
  localparam int unsigned LenW      = $clog2(MaxBytes + 1);
  // 8 bits at CLK_RATIO 4
  localparam int unsigned XferClks  = 32;

  logic            clk_i;
  logic            reset_l_i;
  logic            txn_start_i;
  logic [LenW-1:0] txn_len_i;
  logic            txn_busy_o;
  logic            txn_done_o;
  logic [7:0]      host_tx_byte_i;
  logic            host_tx_valid_i;
  logic            host_tx_ready_o;
  logic [7:0]      host_rx_byte_o;
  logic            host_rx_valid_o;
  logic [7:0]      m_tx_byte_o;
  logic            m_tx_valid_o;
  logic            m_tx_ready_i;
  logic [7:0]      m_rx_byte_i;
  logic            m_rx_valid_i;
  logic            spi_cs_n_o;

  logic            mdl_rx_valid;
  logic            spur_rx;
  assign m_rx_valid_i = mdl_rx_valid | spur_rx;

  spi_txn_ctrl #(
    .MAX_BYTES    (MaxBytes),
    .CS_SETUP_CLKS(SetupClks),
    .CS_HOLD_CLKS (HoldClks),
    .CS_IDLE_CLKS (IdleClks)
  ) dut (
    .clk_i          (clk_i),
    .reset_l_i      (reset_l_i),
    .txn_start_i    (txn_start_i),
    .txn_len_i      (txn_len_i),
    .txn_busy_o     (txn_busy_o),
    .txn_done_o     (txn_done_o),
    .host_tx_byte_i (host_tx_byte_i),
    .host_tx_valid_i(host_tx_valid_i),
    .host_tx_ready_o(host_tx_ready_o),
    .host_rx_byte_o (host_rx_byte_o),
    .host_rx_valid_o(host_rx_valid_o),
    .m_tx_byte_o    (m_tx_byte_o),
    .m_tx_valid_o   (m_tx_valid_o),
    .m_tx_ready_i   (m_tx_ready_i),
    .m_rx_byte_i    (m_rx_byte_i),
    .m_rx_valid_i   (m_rx_valid_i),
    .spi_cs_n_o     (spi_cs_n_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  int unsigned cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Scoreboard and host byte source
  logic [8:0]  exp_q[$];
  logic [7:0]  host_q[$];
  logic [8:0]  exp_b;
  logic [7:0]  hb;
  logic        take;
  int unsigned sent       = 0;
  int unsigned stall_idx  = 32'hFFFF_FFFF;
  int unsigned stall_left = 0;
  int unsigned stall_bad  = 0;
  int unsigned ready_delay = 0;

  // Event monitor
  logic        prev_cs   = 1'b1;
  logic        prev_busy = 1'b0;
  logic        await_mtx = 1'b0;
  int unsigned n_cs_fall = 0, n_cs_rise = 0, n_busy_rise = 0;
  int unsigned n_done = 0, n_mtx = 0, n_rx = 0, n_bad = 0;
  int unsigned cs_fall_cyc, cs_rise_cyc, busy_fall_cyc, done_cyc, first_mtx_cyc, rx_cyc;
  int unsigned start_cyc;

  int unsigned b_cs_fall, b_cs_rise, b_busy_rise, b_done, b_mtx, b_rx;

  initial begin
    forever begin
      @(negedge clk_i);
      if (prev_cs && !spi_cs_n_o) begin
        n_cs_fall++;
        cs_fall_cyc = cyc;
        await_mtx   = 1'b1;
      end
      if (!prev_cs && spi_cs_n_o) begin
        n_cs_rise++;
        cs_rise_cyc = cyc;
      end
      if (!prev_busy && txn_busy_o) n_busy_rise++;
      if (prev_busy && !txn_busy_o) busy_fall_cyc = cyc;
      if (txn_done_o) begin
        n_done++;
        done_cyc = cyc;
        if (!(spi_cs_n_o && !prev_cs)) n_bad++;
      end
      if (m_tx_valid_o) begin
        n_mtx++;
        if (!m_tx_ready_i || spi_cs_n_o) n_bad++;
        if (await_mtx) begin
          first_mtx_cyc = cyc;
          await_mtx     = 1'b0;
        end
      end
      if (host_rx_valid_o) begin
        n_rx++;
        rx_cyc = cyc;
        if (exp_q.size() > 0) exp_b = exp_q.pop_front();
        else exp_b = 9'h100;
        check("rx_byte", {23'd0, 1'b0, host_rx_byte_o}, {23'd0, exp_b});
      end
      prev_cs   = spi_cs_n_o;
      prev_busy = txn_busy_o;
    end
  end

  // Host byte driver; holds valid low for stall_left LOAD cycles before byte stall_idx.
  initial begin
    host_tx_valid_i = 1'b0;
    host_tx_byte_i  = 8'h00;
    forever begin
      @(negedge clk_i);
      take = host_tx_valid_i && host_tx_ready_o && reset_l_i;
      if (sent == stall_idx && stall_left > 0 && host_tx_ready_o) begin
        stall_left--;
        if (m_tx_valid_o || spi_cs_n_o) stall_bad++;
      end
      @(posedge clk_i);
      #1;
      if (take && host_q.size() > 0) begin
        hb = host_q.pop_front();
        sent++;
      end
      host_tx_valid_i = (host_q.size() > 0) && !(sent == stall_idx && stall_left > 0);
      host_tx_byte_i  = (host_q.size() > 0) ? host_q[0] : 8'h00;
    end
  end

  // Byte-level SPI master with MOSI looped to MISO
  logic [7:0] mdl_shift;
  initial begin
    m_tx_ready_i = 1'b1;
    mdl_rx_valid = 1'b0;
    m_rx_byte_i  = 8'h00;
    forever begin
      @(negedge clk_i);
      if (m_tx_valid_o && m_tx_ready_i) begin
        mdl_shift = m_tx_byte_o;
        @(posedge clk_i);
        #1 m_tx_ready_i = 1'b0;
        repeat (XferClks - 1) @(posedge clk_i);
        #1;
        m_rx_byte_i  = mdl_shift;
        mdl_rx_valid = 1'b1;
        @(posedge clk_i);
        #1 mdl_rx_valid = 1'b0;
        repeat (ready_delay) @(posedge clk_i);
        #1 m_tx_ready_i = 1'b1;
      end
    end
  end

  task automatic snap();
    b_cs_fall   = n_cs_fall;
    b_cs_rise   = n_cs_rise;
    b_busy_rise = n_busy_rise;
    b_done      = n_done;
    b_mtx       = n_mtx;
    b_rx        = n_rx;
  endtask

  task automatic start_txn(input int unsigned len);
    @(negedge clk_i);
    txn_start_i = 1'b1;
    txn_len_i   = LenW'(len);
    start_cyc   = cyc;
    @(negedge clk_i);
    txn_start_i = 1'b0;
  endtask

  task automatic queue_bytes(input logic [7:0] b, input bit expect_rx);
    host_q.push_back(b);
    if (expect_rx) exp_q.push_back({1'b0, b});
  endtask

  task automatic wait_done(input int unsigned target, input int unsigned budget, input string tag);
    int unsigned k = 0;
    while (n_done < target && k < budget) begin
      @(negedge clk_i);
      k++;
    end
    check(tag, 32'(n_done >= target), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    int unsigned k = 0;
    while (txn_busy_o && k < 50) begin
      @(negedge clk_i);
      k++;
    end
    check(tag, 32'(txn_busy_o), 32'd0);
    repeat (2) @(negedge clk_i);
  endtask

  task automatic wait_mtx(input int unsigned target, input string tag);
    int unsigned k = 0;
    while (n_mtx < target && k < 300) begin
      @(negedge clk_i);
      k++;
    end
    check(tag, 32'(n_mtx >= target), 32'd1);
  endtask

  int unsigned rise1;

  initial begin
    reset_l_i   = 1'b1;
    txn_start_i = 1'b0;
    txn_len_i   = '0;
    spur_rx     = 1'b0;

    #2 reset_l_i = 1'b0;
    #1;
    check("reset_cs_n", 32'(spi_cs_n_o), 32'd1);
    check("reset_outs", {13'd0, txn_busy_o, txn_done_o, host_tx_ready_o, m_tx_valid_o,
                         host_rx_valid_o, m_tx_byte_o, host_rx_byte_o}, 32'd0);
    repeat (3) @(negedge clk_i);
    reset_l_i = 1'b1;
    repeat (2) @(negedge clk_i);

    // Single byte with exact phase timing
    queue_bytes(8'hA5, 1'b1);
    snap();
    start_txn(1);
    wait_done(b_done + 1, 200, "single_done_seen");
    wait_idle("single_idle");
    check("single_cs_delay", cs_fall_cyc - start_cyc, 32'd1);
    check("single_first_mtx", first_mtx_cyc - cs_fall_cyc, SetupClks + 2);
    check("single_hold", cs_rise_cyc - rx_cyc, HoldClks);
    check("single_done_at_rise", done_cyc, cs_rise_cyc);
    check("single_busy_gap", busy_fall_cyc - done_cyc, IdleClks);
    check("single_rx_count", n_rx - b_rx, 32'd1);

    // Burst of four with a slow master ready
    ready_delay = 3;
    for (int i = 1; i <= 4; i++) queue_bytes(8'(i), 1'b1);
    snap();
    start_txn(4);
    wait_done(b_done + 1, 400, "burst_done_seen");
    wait_idle("burst_idle");
    ready_delay = 0;
    check("burst_rx_count", n_rx - b_rx, 32'd4);
    check("burst_mtx_count", n_mtx - b_mtx, 32'd4);
    check("burst_cs_rises", n_cs_rise - b_cs_rise, 32'd1);
    check("burst_done_count", n_done - b_done, 32'd1);
    check("burst_busy_gap", busy_fall_cyc - done_cyc, IdleClks);
    check("burst_sb_empty", exp_q.size(), 32'd0);

    // Host underrun before byte 2
    queue_bytes(8'h11, 1'b1);
    queue_bytes(8'h22, 1'b1);
    queue_bytes(8'h33, 1'b1);
    stall_idx  = sent + 1;
    stall_left = 20;
    snap();
    start_txn(3);
    wait_done(b_done + 1, 400, "underrun_done_seen");
    wait_idle("underrun_idle");
    check("underrun_stall_ran", stall_left, 32'd0);
    check("underrun_quiet", stall_bad, 32'd0);
    check("underrun_cs_rises", n_cs_rise - b_cs_rise, 32'd1);
    check("underrun_rx_count", n_rx - b_rx, 32'd3);
    stall_idx = 32'hFFFF_FFFF;

    // Zero length and a stray master rx pulse while idle
    snap();
    start_txn(0);
    @(negedge clk_i);
    spur_rx = 1'b1;
    @(negedge clk_i);
    spur_rx = 1'b0;
    repeat (20) @(negedge clk_i);
    check("len0_cs", n_cs_fall - b_cs_fall, 32'd0);
    check("len0_busy", n_busy_rise - b_busy_rise, 32'd0);
    check("idle_rx_ignored", n_rx - b_rx, 32'd0);

    // Over-length request is clamped to MaxBytes
    for (int i = 0; i < int'(MaxBytes) + 5; i++) queue_bytes(8'(8'h40 + i), i < int'(MaxBytes));
    snap();
    start_txn(MaxBytes + 5);
    wait_done(b_done + 1, 1200, "clamp_done_seen");
    wait_idle("clamp_idle");
    check("clamp_rx_count", n_rx - b_rx, MaxBytes);
    check("clamp_mtx_count", n_mtx - b_mtx, MaxBytes);
    check("clamp_leftover", host_q.size(), 32'd5);
    host_q.delete();
    repeat (2) @(negedge clk_i);

    // Start while busy is ignored
    queue_bytes(8'h5A, 1'b1);
    queue_bytes(8'hC3, 1'b1);
    snap();
    start_txn(2);
    wait_mtx(b_mtx + 1, "busy_mtx_seen");
    start_txn(5);
    wait_done(b_done + 1, 400, "busy_done_seen");
    wait_idle("busy_idle");
    repeat (10) @(negedge clk_i);
    check("busy_rx_count", n_rx - b_rx, 32'd2);
    check("busy_cs_falls", n_cs_fall - b_cs_fall, 32'd1);
    check("busy_done_count", n_done - b_done, 32'd1);

    // Reset during byte 2 of four
    for (int i = 0; i < 4; i++) queue_bytes(8'(8'hE0 + i), 1'b1);
    snap();
    start_txn(4);
    wait_mtx(b_mtx + 2, "rst_mtx2_seen");
    @(negedge clk_i);
    reset_l_i = 1'b0;
    #1;
    check("rst_cs_n", 32'(spi_cs_n_o), 32'd1);
    check("rst_outs", {13'd0, txn_busy_o, txn_done_o, host_tx_ready_o, m_tx_valid_o,
                       host_rx_valid_o, m_tx_byte_o, host_rx_byte_o}, 32'd0);
    host_q.delete();
    exp_q.delete();
    snap();
    repeat (40) @(negedge clk_i);
    check("rst_no_done", n_done - b_done, 32'd0);
    check("rst_no_pulses", (n_mtx - b_mtx) + (n_rx - b_rx), 32'd0);
    reset_l_i = 1'b1;
    repeat (10) @(negedge clk_i);
    queue_bytes(8'h3C, 1'b1);
    snap();
    start_txn(1);
    wait_done(b_done + 1, 200, "post_rst_done_seen");
    wait_idle("post_rst_idle");
    check("post_rst_rx_count", n_rx - b_rx, 32'd1);

    // Back-to-back: second start the first cycle busy is low
    queue_bytes(8'h81, 1'b1);
    queue_bytes(8'h7E, 1'b1);
    snap();
    start_txn(1);
    wait_done(b_done + 1, 200, "b2b_first_done");
    rise1 = cs_rise_cyc;
    begin
      int unsigned k = 0;
      while (txn_busy_o && k < 50) begin
        @(negedge clk_i);
        k++;
      end
    end
    txn_start_i = 1'b1;
    txn_len_i   = LenW'(1);
    @(negedge clk_i);
    txn_start_i = 1'b0;
    wait_done(b_done + 2, 200, "b2b_second_done");
    wait_idle("b2b_idle");
    check("b2b_cs_gap", 32'((cs_fall_cyc - rise1) >= IdleClks), 32'd1);
    check("b2b_cs_falls", n_cs_fall - b_cs_fall, 32'd2);
    check("b2b_rx_count", n_rx - b_rx, 32'd2);

    check("protocol_violations", n_bad, 32'd0);
    check("sb_drained", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
